// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with TX FIFO, run flag and selectable bit divider
module uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_B0     = 868,
    parameter int DIV_B1     = 434,
    parameter int DIV_B2     = 217,
    parameter int DIV_B3     = 108
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_wdata,
    input  logic       fifo_wen,
    output logic       fifo_wready,
    input  logic [1:0] baud,
    input  logic       txen,
    input  logic       txst,
    output logic       busy,
    output logic       txf,
    output logic       tx_int,
    output logic       txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          run;
    logic [15:0]   timer;
    logic [15:0]   div_lat;
    logic [15:0]   div_m1;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic full, empty, push, pop, bit_end, go, frame_end;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign fifo_wready = !full;
    assign txf         = full;
    // Push uses the pre-pop full flag: a full FIFO never accepts in the pop cycle.
    assign push        = fifo_wen && !full;
    assign bit_end     = (timer == 16'd0);
    assign go          = run && txen && !empty;
    assign busy        = (state != IDLE);

    always_comb begin
        div_m1 = 16'(DIV_B0 - 1);
        case (baud)
            2'd0:    div_m1 = 16'(DIV_B0 - 1);
            2'd1:    div_m1 = 16'(DIV_B1 - 1);
            2'd2:    div_m1 = 16'(DIV_B2 - 1);
            default: div_m1 = 16'(DIV_B3 - 1);
        endcase
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    if (go) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_int = frame_end && empty && !push;

    always_comb begin
        txd = 1'b1;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= fifo_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            run     <= 1'b0;
            timer   <= '0;
            div_lat <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_next;

            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Frame end with nothing left to send drops run, as does txen low between frames.
            if (txst && txen)
                run <= 1'b1;
            else if (tx_int || (!txen && (state == IDLE || frame_end)))
                run <= 1'b0;

            if (pop) begin
                div_lat <= div_m1;
                timer   <= div_m1;
                shreg   <= mem[rptr];
                bit_cnt <= '0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    timer <= div_lat;
                    if (state == DATA) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

endmodule
